// File: rtl/clmul_pkg.sv
// Shared types for the Zbc carry-less multiply unit.
package clmul_pkg;

  typedef enum logic [1:0] {
    CLMUL  = 2'b00,
    CLMULH = 2'b01,
    CLMULR = 2'b10,
    RSVD   = 2'b11
  } clmul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } clmul_state_e;

endpackage

// File: rtl/clmul_zbc_if.sv
// Request/response bus of the carry-less multiply unit.
interface clmul_zbc_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (output in_valid, op, a, b, out_ready,
                  input  in_ready, out_valid, result);
  modport slave  (input  in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, result);
endinterface

// File: rtl/clmul_step.sv
// One iteration of the carry-less multiply: XOR in BPC shifted partial products.
module clmul_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 8
) (
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [2*XLEN-1:0] a_sh,
  input  logic [BPC-1:0]    b_bits,
  output logic [2*XLEN-1:0] acc_out
);

  always_comb begin
    acc_out = acc_in;
    for (int i = 0; i < BPC; i++) begin
      if (b_bits[i]) acc_out = acc_out ^ (a_sh << i);
    end
  end

endmodule

// File: rtl/clmul_zbc.sv
// Iterative Zbc carry-less multiplier (CLMUL/CLMULH/CLMULR), BPC multiplier bits per cycle.
// state | meaning
// IDLE  | waiting for a request
// BUSY  | accumulating partial products, cnt_q steps left
// DONE  | result valid, waiting for out_ready
module clmul_zbc
  import clmul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         stall,
  input  logic         flush,
  clmul_zbc_if.slave   bus
);

  localparam int N     = XLEN / BPC;
  localparam int CNT_W = $clog2(N + 1);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("clmul_zbc: XLEN must be 32 or 64");
  end
  if (!(BPC >= 1 && BPC <= XLEN && ((BPC & (BPC - 1)) == 0))) begin : g_bad_bpc
    $error("clmul_zbc: BPC must be a power of two between 1 and XLEN");
  end

  clmul_state_e      state_q, state_d;
  clmul_op_e         op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] a_sh_q, a_sh_d;
  logic [XLEN-1:0]   b_sh_q, b_sh_d;
  logic [2*XLEN-1:0] step_acc;
  logic              accept;

  clmul_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
    .acc_in  (acc_q),
    .a_sh    (a_sh_q),
    .b_bits  (b_sh_q[BPC-1:0]),
    .acc_out (step_acc)
  );

  assign bus.in_ready  = !stall && ((state_q == IDLE) || (state_q == DONE && bus.out_ready));
  assign bus.out_valid = (state_q == DONE);
  assign accept        = bus.in_valid && bus.in_ready && !flush;

  always_comb begin
    case (op_q)
      CLMULH:  bus.result = acc_q[2*XLEN-1:XLEN];
      CLMULR:  bus.result = acc_q[2*XLEN-2:XLEN-1];
      default: bus.result = acc_q[XLEN-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    if (flush) begin
      state_d = IDLE;
    end else if (!stall) begin
      case (state_q)
        BUSY: begin
          acc_d  = step_acc;
          a_sh_d = a_sh_q << BPC;
          b_sh_d = b_sh_q >> BPC;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
        DONE:    if (bus.out_ready) state_d = IDLE;
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
      // accept is only possible from IDLE or a completing DONE
      if (accept) begin
        state_d = BUSY;
        op_d    = clmul_op_e'(bus.op);
        cnt_d   = CNT_W'(N);
        acc_d   = '0;
        a_sh_d  = {{XLEN{1'b0}}, bus.a};
        b_sh_d  = bus.b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q    <= CLMUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
    end
  end

endmodule
